sr_reg_arbiter: RTL and testbench

Round-robin controller that shares one WIDTH-bit set/clear register between NREQ requesters. Each requester presents per-bit set and clear masks. The block grants one requester at a time, applies that requester's masks to the register with SR semantics (illegal S=R=1 bits are suppressed and flagged), and returns a one-cycle completion pulse. It sits between the control agents and the shared status/flag register built from the team's SR flip-flop style.

---
 rtl/sr_reg_arbiter.sv | 136 +++++++++++++
 tb/tb_sr_reg_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sr_reg_arbiter.sv
// Round-robin arbiter that shares one set/clear register between NREQ requesters.
// One requester is granted at a time. Its latched masks are applied with SR semantics, and done pulses back to it.
module sr_reg_arbiter #(
   parameter int               NREQ    = 4,
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NREQ-1:0]       req_i,
   input  logic [NREQ*WIDTH-1:0] set_mask_i,
   input  logic [NREQ*WIDTH-1:0] clr_mask_i,
   output logic [NREQ-1:0]       gnt_o,
   output logic [NREQ-1:0]       done_o,
   output logic                  err_o,
   output logic                  busy_o,
   output logic [WIDTH-1:0]      reg_q_o
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      DONE
   } state_e;

   state_e            state_q, state_d;
   logic [IDXW-1:0]   last_q, last_d;
   logic [IDXW-1:0]   winner_q, winner_d;
   logic [WIDTH-1:0]  set_q, set_d;
   logic [WIDTH-1:0]  clr_q, clr_d;
   logic [WIDTH-1:0]  reg_q, reg_d;

   logic              found;
   logic [IDXW-1:0]   winIdx;
   logic [WIDTH-1:0]  setSel;
   logic [WIDTH-1:0]  clrSel;
   logic [NREQ-1:0]   winOneHot;

   // The search starts just past the last granted index, so the most recent winner gets lowest priority.
   always_comb begin
      found  = 1'b0;
      winIdx = '0;
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = (int'(last_q) + k) % NREQ;
         if (!found && req_i[idx]) begin
            found  = 1'b1;
            winIdx = IDXW'(idx);
         end
      end
   end

   always_comb begin
      setSel = '0;
      clrSel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (IDXW'(i) == winIdx) begin
            setSel = set_mask_i[i*WIDTH +: WIDTH];
            clrSel = clr_mask_i[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      winOneHot = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (IDXW'(i) == winner_q) begin
            winOneHot[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      winner_d = winner_q;
      set_d    = set_q;
      clr_d    = clr_q;
      reg_d    = reg_q;
      gnt_o    = '0;
      done_o   = '0;
      err_o    = 1'b0;
      busy_o   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               winner_d = winIdx;
               set_d    = setSel;
               clr_d    = clrSel;
               state_d  = GRANT;
            end
         end
         GRANT: begin
            gnt_o   = winOneHot;
            busy_o  = 1'b1;
            // Bits with S=C=1 fall out of both terms, so they hold their value.
            reg_d   = (reg_q | (set_q & ~clr_q)) & ~(clr_q & ~set_q);
            state_d = DONE;
         end
         DONE: begin
            gnt_o   = winOneHot;
            done_o  = winOneHot;
            err_o   = |(set_q & clr_q);
            busy_o  = 1'b1;
            last_d  = winner_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         last_q   <= IDXW'(NREQ - 1);
         winner_q <= '0;
         set_q    <= '0;
         clr_q    <= '0;
         reg_q    <= RST_VAL;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         winner_q <= winner_d;
         set_q    <= set_d;
         clr_q    <= clr_d;
         reg_q    <= reg_d;
      end
   end

   assign reg_q_o = reg_q;

endmodule

// File: tb/tb_sr_reg_arbiter.sv
// Self-checking bench for sr_reg_arbiter.
// Drivers push hand-computed expected updates into a queue, and a monitor checks them whenever done pulses.
module tb_sr_reg_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;

   logic                  clk_i;
   logic                  rst_ni;
   logic [NREQ-1:0]       req_i;
   logic [NREQ*WIDTH-1:0] set_mask_i;
   logic [NREQ*WIDTH-1:0] clr_mask_i;
   logic [NREQ-1:0]       gnt_o;
   logic [NREQ-1:0]       done_o;
   logic                  err_o;
   logic                  busy_o;
   logic [WIDTH-1:0]      reg_q_o;

   typedef struct {
      int               idx;
      logic [WIDTH-1:0] regVal;
      logic             err;
   } exp_t;

   exp_t sbQ[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   sr_reg_arbiter #(
      .NREQ(NREQ),
      .WIDTH(WIDTH),
      .RST_VAL('1)
   ) dut (
      .clk_i(clk_i),
      .rst_ni(rst_ni),
      .req_i(req_i),
      .set_mask_i(set_mask_i),
      .clr_mask_i(clr_mask_i),
      .gnt_o(gnt_o),
      .done_o(done_o),
      .err_o(err_o),
      .busy_o(busy_o),
      .reg_q_o(reg_q_o)
   );

   // Free-running clock plus a cycle counter used to measure spacing between done pulses.
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // The monitor pops one expectation per done pulse and checks grant, register contents and err together.
   always @(negedge clk_i) begin
      if (rst_ni && done_o != '0) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpectedDone", 32'(done_o), 32'h0);
         end else begin
            exp_t e;
            e = sbQ.pop_front();
            checkOutput("doneIdx", 32'(done_o), 32'(1 << e.idx));
            checkOutput("gntWithDone", 32'(gnt_o), 32'(1 << e.idx));
            checkOutput("regAtDone", 32'(reg_q_o), 32'(e.regVal));
            checkOutput("errAtDone", 32'(err_o), 32'(e.err));
         end
      end
   end

   task automatic waitDone(input logic [NREQ-1:0] mask, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         if ((done_o & mask) != '0) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("doneInTime", 32'(ok), 32'h1);
   endtask

   // One isolated operation for a single requester, optionally changing its set mask while granted.
   task automatic applyStimulus(input int idx, input logic [WIDTH-1:0] setV, input logic [WIDTH-1:0] clrV,
                                input logic [WIDTH-1:0] expReg, input logic expErr,
                                input bit changeSet, input logic [WIDTH-1:0] newSet);
      exp_t e;
      bit   ok;
      @(negedge clk_i);
      set_mask_i[idx*WIDTH +: WIDTH] = setV;
      clr_mask_i[idx*WIDTH +: WIDTH] = clrV;
      req_i[idx] = 1'b1;
      e.idx = idx;
      e.regVal = expReg;
      e.err = expErr;
      sbQ.push_back(e);
      @(posedge clk_i);
      #1;
      checkOutput("gntAfterReq", 32'(gnt_o), 32'(1 << idx));
      checkOutput("busyInGrant", 32'(busy_o), 32'h1);
      if (changeSet) begin
         set_mask_i[idx*WIDTH +: WIDTH] = newSet;
      end
      waitDone(4'(1 << idx), ok);
      req_i[idx] = 1'b0;
      @(posedge clk_i);
      #1;
      checkOutput("gntIdleAfter", 32'(gnt_o), 32'h0);
      checkOutput("busyIdleAfter", 32'(busy_o), 32'h0);
      set_mask_i = '0;
      clr_mask_i = '0;
   endtask

   initial begin
      bit ok;
      int lastDone;
      exp_t e;

      rst_ni     = 1'b0;
      req_i      = '0;
      set_mask_i = '0;
      clr_mask_i = '0;
      #12;
      checkOutput("resetReg", 32'(reg_q_o), 32'hFF);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Idle after reset: nothing should move for ten cycles.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         checkOutput("idleOutputs", {reg_q_o, gnt_o, done_o, err_o, busy_o}, {8'hFF, 4'h0, 4'h0, 1'b0, 1'b0});
      end

      applyStimulus(2, 8'h00, 8'h0F, 8'hF0, 1'b0, 1'b0, 8'h00);
      applyStimulus(3, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00);
      applyStimulus(1, 8'h81, 8'h01, 8'h80, 1'b1, 1'b0, 8'h00);
      applyStimulus(0, 8'h01, 8'h00, 8'h81, 1'b0, 1'b1, 8'hFF);
      checkOutput("regHeldAfterOps", 32'(reg_q_o), 32'h81);

      // Reset mid-operation discards the in-flight update and never pulses done.
      @(negedge clk_i);
      clr_mask_i[2*WIDTH +: WIDTH] = 8'hFF;
      req_i[2] = 1'b1;
      @(posedge clk_i);
      #1;
      checkOutput("gntBeforeAbort", 32'(gnt_o), 32'h4);
      rst_ni = 1'b0;
      #1;
      checkOutput("abortOutputs", {reg_q_o, gnt_o, done_o, err_o, busy_o}, {8'hFF, 4'h0, 4'h0, 1'b0, 1'b0});
      @(negedge clk_i);
      req_i = '0;
      clr_mask_i = '0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Round robin with all four held after reset: order 0,1,2,3,0.
      set_mask_i = '0;
      clr_mask_i = {8'h08, 8'h04, 8'h02, 8'h01};
      req_i = 4'hF;
      e.err = 1'b0;
      e.idx = 0; e.regVal = 8'hFE; sbQ.push_back(e);
      e.idx = 1; e.regVal = 8'hFC; sbQ.push_back(e);
      e.idx = 2; e.regVal = 8'hF8; sbQ.push_back(e);
      e.idx = 3; e.regVal = 8'hF0; sbQ.push_back(e);
      e.idx = 0; e.regVal = 8'hF1; sbQ.push_back(e);
      @(posedge clk_i);
      #1;
      checkOutput("firstWinnerAfterReset", 32'(gnt_o), 32'h1);
      lastDone = 0;
      for (int n = 0; n < 5; n++) begin
         waitDone(4'hF, ok);
         if (!ok) break;
         if (n > 0) begin
            checkOutput("rrSpacing", 32'(cyc - lastDone), 32'd3);
         end
         lastDone = cyc;
         if (n == 0) begin
            set_mask_i[0 +: WIDTH] = 8'h01;
            clr_mask_i[0 +: WIDTH] = 8'h00;
         end
         if (n == 4) begin
            req_i = '0;
         end
      end

      repeat (4) @(negedge clk_i);
      checkOutput("finalIdle", {reg_q_o, gnt_o, busy_o}, {8'hF1, 4'h0, 1'b0});
      checkOutput("scoreboardEmpty", 32'(sbQ.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
